sync_fifo_flags: RTL and testbench

- Single-clock, parametrised FIFO; the single-clock successor to the dual-clock FIFO.
- Used where producer and consumer share one clock, so no pointer synchronisers are needed.
- Adds over the dual-clock FIFO: fill-level output, programmable almost-full/almost-empty flags, synchronous flush, sticky overflow/underflow error flags, and an optional first-word-fall-through read mode.

---
 rtl/sync_fifo_flags.sv | 116 +++++++++++
 tb/tb_sync_fifo_flags.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered level/almost flags, synchronous flush and sticky ovf/udf.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads (rdv = ~rempty, rrq pops the head).
// Handshake: a write is taken when wdv=1 and wfull=0; a pop is taken when rrq=1 and rempty=0.
// Requests made against a full or empty FIFO are dropped and latch ovf or udf.

module sync_fifo_flags #(
    parameter int DWIDTH        = 16,
    parameter int AWIDTH        = 5,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              flush,
    input  logic              wdv,
    input  logic [DWIDTH-1:0] wdata,
    output logic              wfull,
    output logic              afull,
    input  logic              rrq,
    output logic              rdv,
    output logic [DWIDTH-1:0] rdata,
    output logic              rempty,
    output logic              aempty,
    output logic [AWIDTH:0]   level,
    output logic              ovf,
    output logic              udf
);

    localparam int              DEPTH = 2**AWIDTH;
    localparam logic [AWIDTH:0] AF_L  = (AWIDTH+1)'(AFULL_THRESH);
    localparam logic [AWIDTH:0] AE_L  = (AWIDTH+1)'(AEMPTY_THRESH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH:0]   wptr, rptr, wptr_nx, rptr_nx, level_nx;
    logic              wr_ok, rd_ok, full_nx;

    assign wr_ok = wdv & ~wfull & ~flush;
    assign rd_ok = rrq & ~rempty & ~flush;

    always_comb begin
        wptr_nx = wptr + {{AWIDTH{1'b0}}, wr_ok};
        rptr_nx = rptr + {{AWIDTH{1'b0}}, rd_ok};
        if (flush) begin
            wptr_nx = '0;
            rptr_nx = '0;
        end
        // Full: same address, opposite wrap bit; the subtraction then yields DEPTH, not 0.
        level_nx = wptr_nx - rptr_nx;
        full_nx  = (wptr_nx[AWIDTH-1:0] == rptr_nx[AWIDTH-1:0]) &&
                   (wptr_nx[AWIDTH] != rptr_nx[AWIDTH]);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            level  <= '0;
            wfull  <= 1'b0;
            afull  <= 1'b0;
            rempty <= 1'b1;
            aempty <= 1'b1;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            wptr   <= wptr_nx;
            rptr   <= rptr_nx;
            level  <= level_nx;
            wfull  <= full_nx;
            afull  <= (level_nx >= AF_L);
            rempty <= (level_nx == '0);
            aempty <= (level_nx <= AE_L);
            if (flush) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                if (wdv && wfull) ovf <= 1'b1;
                if (rrq && rempty) udf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr[AWIDTH-1:0]] <= wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic [DWIDTH-1:0] head_nx;

    // The next head is the word being written this edge when everything older has been popped.
    always_comb begin
        head_nx = rdata;
        if (level_nx != '0) begin
            if (wr_ok && (rptr_nx == wptr)) head_nx = wdata;
            else                            head_nx = mem[rptr_nx[AWIDTH-1:0]];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) rdata <= '0;
        else         rdata <= head_nx;
    end

    assign rdv = ~rempty;
`else
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rdv   <= 1'b0;
            rdata <= '0;
        end else begin
            rdv <= rd_ok;
            if (rd_ok) rdata <= mem[rptr[AWIDTH-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: directed test-plan scenarios plus random traffic, all checked
// every cycle against a queue model of the FIFO contents.

module tb_sync_fifo_flags;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wdv = 1'b0;
    logic [15:0] wdata = '0;
    logic        rrq = 1'b0;
    logic        wfull, afull, rdv, rempty, aempty, ovf, udf;
    logic [15:0] rdata;
    logic [5:0]  level;

    sync_fifo_flags dut (
        .clk(clk), .arst_n(arst_n), .flush(flush), .wdv(wdv), .wdata(wdata),
        .wfull(wfull), .afull(afull), .rrq(rrq), .rdv(rdv), .rdata(rdata),
        .rempty(rempty), .aempty(aempty), .level(level), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    endtask

    // Model: FIFO contents as a queue, plus the registered read port and sticky flags.
    logic [15:0] exp_q[$];
    bit          m_rdv = 1'b0;
    logic [15:0] m_rdata = '0;
    bit          m_ovf = 1'b0, m_udf = 1'b0;
    bit          was_full, was_empty;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            exp_q.delete();
            m_rdv = 1'b0; m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (flush) begin
            exp_q.delete();
            m_rdv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            was_full  = (exp_q.size() == 32);
            was_empty = (exp_q.size() == 0);
            m_rdv = 1'b0;
            if (rrq && !was_empty) begin
                m_rdata = exp_q.pop_front();
                m_rdv   = 1'b1;
            end
            if (rrq && was_empty) m_udf = 1'b1;
            if (wdv && !was_full) exp_q.push_back(wdata);
            if (wdv && was_full)  m_ovf = 1'b1;
        end
    end

    bit          e_rdv;
    logic [15:0] e_rdata;

    always @(negedge clk) begin
        if (check_en) begin
            chk("level",  level,  exp_q.size());
            chk("wfull",  wfull,  exp_q.size() == 32);
            chk("afull",  afull,  exp_q.size() >= 28);
            chk("rempty", rempty, exp_q.size() == 0);
            chk("aempty", aempty, exp_q.size() <= 4);
            chk("ovf",    ovf,    m_ovf);
            chk("udf",    udf,    m_udf);
`ifdef SYNC_FIFO_FWFT_EN
            e_rdv   = (exp_q.size() != 0);
            e_rdata = e_rdv ? exp_q[0] : '0;
`else
            e_rdv   = m_rdv;
            e_rdata = m_rdata;
`endif
            chk("rdv", rdv, e_rdv);
            if (e_rdv) chk("rdata", rdata, e_rdata);
        end
    end

    task automatic step(input logic w, input logic [15:0] d, input logic r, input logic f);
        wdv = w; wdata = d; rrq = r; flush = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_level"},  level,  0);
        chk({tag, "_rempty"}, rempty, 1);
        chk({tag, "_aempty"}, aempty, 1);
        chk({tag, "_wfull"},  wfull,  0);
        chk({tag, "_afull"},  afull,  0);
        chk({tag, "_rdv"},    rdv,    0);
        chk({tag, "_rdata"},  rdata,  0);
        chk({tag, "_ovf"},    ovf,    0);
        chk({tag, "_udf"},    udf,    0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        arst_n   = 1'b1;
        check_en = 1'b1;

        // Fill with 0..31; afull first at level 28, full at 32, then an overflow attempt.
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0);
            chk("fill_level", level, i + 1);
            chk("fill_afull", afull, (i + 1) >= 28);
        end
        chk("full_wfull", wfull, 1);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0);
        chk("ovf_set", ovf, 1);
        chk("ovf_level", level, 32);

        // Drain and verify order, then underflow.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
            chk("drain_rdv", rdv, i != 31);
            if (i != 31) chk("drain_rdata", rdata, i + 1);
`else
            chk("drain_rdv", rdv, 1);
            chk("drain_rdata", rdata, i);
`endif
        end
        chk("drained_rempty", rempty, 1);
        chk("drained_level", level, 0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("udf_set", udf, 1);
        chk("udf_rdv", rdv, 0);

        // Streaming at level 5 with pointers wrapping several times.
        step(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
        chk("stream_level", level, 5);
        chk("stream_ovf", ovf, 0);
        chk("stream_udf", udf, 0);

        step(1'b0, 16'h0, 1'b0, 1'b1);
`ifdef SYNC_FIFO_FWFT_EN
        step(1'b1, 16'hA5A5, 1'b0, 1'b0);
        chk("fwft_rdv", rdv, 1);
        chk("fwft_rdata", rdata, 16'hA5A5);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("fwft_pop_rdv", rdv, 0);
        chk("fwft_pop_rempty", rempty, 1);
`else
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("wr_rd_empty_udf", udf, 1);
        chk("wr_rd_empty_rdv", rdv, 0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("late_read_rdv", rdv, 1);
        chk("late_read_rdata", rdata, 16'h1234);
`endif

        // Flush with a concurrent write at level 10 with ovf set.
        step(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 33; i++) step(1'b1, 16'(16'h100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 22; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("pre_flush_level", level, 10);
        chk("pre_flush_ovf", ovf, 1);
        step(1'b1, 16'hDEAD, 1'b0, 1'b1);
        chk("flush_level", level, 0);
        chk("flush_rempty", rempty, 1);
        chk("flush_aempty", aempty, 1);
        chk("flush_ovf", ovf, 0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("flush_write_dropped", level, 0);

        // Random traffic: write-heavy then read-heavy, rare flushes.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < (i < 200 ? 70 : 30)) ? 1'b1 : 1'b0,
                 16'($urandom),
                 ($urandom_range(0, 99) < (i < 200 ? 30 : 70)) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset mid-stream at level 7.
        step(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'($urandom), 1'b1, 1'b0);
        chk("pre_reset_level", level, 7);
        wdv = 1'b0; rrq = 1'b0;
        @(posedge clk);
        #2 arst_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        arst_n = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
